// File: rtl/drbg_responder.sv
// Generator-side end of the DRBG block handshake: prefetches one block from the hash
// DRBG core, presents it on request for a fixed hold window, and forces periodic reseeds.
module drbg_responder #(
  parameter int DATA_WIDTH      = 256,
  parameter int HOLD_CYCLES     = 32,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  need_next,
  output logic                  generator_busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  core_generate,
  output logic                  core_reseed,
  input  logic                  core_busy,
  input  logic [DATA_WIDTH-1:0] core_data,
  input  logic                  core_data_valid,
  input  logic                  core_reseed_done,
  output logic                  protocol_err
);
  localparam int GCW = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [GCW-1:0] GC_MAX    = GCW'(RESEED_INTERVAL);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam bit             RESEED_EN = (RESEED_INTERVAL != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_WAIT_CORE, S_FULL, S_PRESENT, S_RESEED, S_RESEED_WAIT
  } state_t;

  typedef struct packed {
    logic gen_busy;
    logic valid;
    logic gen;
    logic reseed;
    logic err;
    logic pending;
  } ctl_t;

  localparam ctl_t CTL_RST = '{gen_busy: 1'b1, default: 1'b0};

  state_t                state, state_d;
  ctl_t                  ctl, ctl_d;
  logic [GCW-1:0]        gen_count, gen_count_d;
  logic [HCW-1:0]        hold_cnt, hold_cnt_d;
  logic [DATA_WIDTH-1:0] buffer;
  logic                  buf_ld, dout_ld;
  logic                  reseed_due;

  assign reseed_due = RESEED_EN && (gen_count == GC_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:        state_d = S_GEN;
      S_GEN:         if (reseed_due)                state_d = S_RESEED;
                     else if (!core_busy)           state_d = S_WAIT_CORE;
      S_WAIT_CORE:   if (core_data_valid)           state_d = S_FULL;
      S_FULL:        if (need_next || ctl.pending)  state_d = S_PRESENT;
      S_PRESENT:     if (hold_cnt == '0)            state_d = S_GEN;
      S_RESEED:      if (!core_busy)                state_d = S_RESEED_WAIT;
      S_RESEED_WAIT: if (core_reseed_done)          state_d = S_GEN;
      default:                                      state_d = S_IDLE;
    endcase
  end

  // Next values of every registered output; start pulses default low so they last one cycle.
  always_comb begin
    ctl_d        = ctl;
    ctl_d.gen    = 1'b0;
    ctl_d.reseed = 1'b0;
    gen_count_d  = gen_count;
    hold_cnt_d   = hold_cnt;
    buf_ld       = 1'b0;
    dout_ld      = 1'b0;
    if (need_next && state != S_FULL) ctl_d.pending = 1'b1;
    if ((core_data_valid && state != S_WAIT_CORE) ||
        (core_reseed_done && state != S_RESEED_WAIT)) ctl_d.err = 1'b1;
    case (state)
      S_GEN: if (!reseed_due && !core_busy) ctl_d.gen = 1'b1;
      S_WAIT_CORE: if (core_data_valid) begin
        buf_ld = 1'b1;
        if (gen_count != GC_MAX) gen_count_d = gen_count + 1'b1;
      end
      S_FULL: if (need_next || ctl.pending) begin
        dout_ld        = 1'b1;
        ctl_d.valid    = 1'b1;
        ctl_d.gen_busy = 1'b1;
        ctl_d.pending  = 1'b0;
        hold_cnt_d     = HOLD_LAST;
      end else begin
        ctl_d.gen_busy = 1'b0;
      end
      S_PRESENT: if (hold_cnt == '0) ctl_d.valid = 1'b0;
                 else                hold_cnt_d  = hold_cnt - 1'b1;
      S_RESEED: if (!core_busy) begin
        ctl_d.reseed = 1'b1;
        gen_count_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl       <= CTL_RST;
      gen_count <= '0;
      hold_cnt  <= '0;
      buffer    <= '0;
      data_out  <= '0;
    end else begin
      ctl       <= ctl_d;
      gen_count <= gen_count_d;
      hold_cnt  <= hold_cnt_d;
      if (buf_ld)  buffer   <= core_data;
      if (dout_ld) data_out <= buffer;
    end
  end

  assign generator_busy = ctl.gen_busy;
  assign data_out_valid = ctl.valid;
  assign core_generate  = ctl.gen;
  assign core_reseed    = ctl.reseed;
  assign protocol_err   = ctl.err;
endmodule

// File: tb/tb_drbg_responder.sv
// Bench for drbg_responder: a behavioural DRBG core feeds a block scoreboard, a vector
// table walks request timings across reseed boundaries, hand sequences cover busy/stray/reset.
module tb_drbg_responder;
  localparam int W        = 256;
  localparam int HOLD     = 32;
  localparam int RI       = 2;
  localparam int CORE_LAT = 5;
  localparam int RS_LAT   = 3;

  logic         clk = 1'b0, reset = 1'b1, need_next = 1'b0, core_busy = 1'b0;
  logic         generator_busy, data_out_valid, core_generate, core_reseed, protocol_err;
  logic [W-1:0] data_out, core_data;
  logic         core_data_valid, core_reseed_done;
  logic         model_dv = 1'b0, model_done = 1'b0, man_dv = 1'b0;
  logic [W-1:0] model_data = '0, man_data = '0;

  assign core_data_valid  = model_dv | man_dv;
  assign core_data        = man_dv ? man_data : model_data;
  assign core_reseed_done = model_done;

  drbg_responder #(.DATA_WIDTH(W), .HOLD_CYCLES(HOLD), .RESEED_INTERVAL(RI)) dut (
    .clk(clk), .reset(reset), .need_next(need_next), .generator_busy(generator_busy),
    .data_out(data_out), .data_out_valid(data_out_valid), .core_generate(core_generate),
    .core_reseed(core_reseed), .core_busy(core_busy), .core_data(core_data),
    .core_data_valid(core_data_valid), .core_reseed_done(core_reseed_done),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Core model: answers each generate/reseed pulse after a fixed latency, driving on negedges.
  logic [W-1:0] exp_q[$];
  int           gen_n = 0;
  initial begin : core_model
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (core_generate) begin
        repeat (CORE_LAT) @(negedge clk);
        gen_n++;
        w = 32'(gen_n) * 32'h9E37_79B1 + 32'h0BAD_F00D;
        model_data = {4{w, ~w}};
        exp_q.push_back(model_data);
        model_dv = 1'b1;
        @(negedge clk);
        model_dv = 1'b0;
      end else if (core_reseed) begin
        repeat (RS_LAT) @(negedge clk);
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_chk = 0, n_fail = 0, rd_idx = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one refill until the core delivers a block; optionally requests while it runs.
  task automatic refill(input bit exp_rs, input int dly, input int len, input logic [W-1:0] held);
    int gens = 0, rss = 0;
    bit done_seen = 0, got = 0, order_ok = 1, valid_seen = 0, data_ok = 1;
    for (int c = 0; c < 300 && !got; c++) begin
      need_next = (c >= dly) && (c < dly + len);
      tick;
      if (core_reseed) rss++;
      if (core_reseed_done) done_seen = 1;
      if (core_generate) begin
        gens++;
        if (exp_rs && !done_seen) order_ok = 0;
      end
      if (data_out_valid) valid_seen = 1;
      if (data_out !== held) data_ok = 0;
      if (core_data_valid) got = 1;
    end
    need_next = 1'b0;
    check("refill_capture", got, 1'b1);
    check("refill_gen_pulses", gens, 1);
    check("refill_reseed_pulses", rss, exp_rs ? 1 : 0);
    check("refill_gen_after_reseed_done", order_ok, 1'b1);
    check("refill_valid_low", valid_seen, 1'b0);
    check("refill_data_held", data_ok, 1'b1);
  endtask

  task automatic present(input bit early, input bit exp_perr, output logic [W-1:0] blk);
    check("sb_block_available", rd_idx < exp_q.size(), 1'b1);
    blk = (rd_idx < exp_q.size()) ? exp_q[rd_idx] : '0;
    rd_idx++;
    if (!early) begin
      tick;
      check("busy_drop", generator_busy, 1'b0);
      check("valid_idle", data_out_valid, 1'b0);
      need_next = 1'b1;
      tick;
      need_next = 1'b0;
    end else begin
      tick;
    end
    check("valid_rise", data_out_valid, 1'b1);
    check("busy_present", generator_busy, 1'b1);
    check("data_out", data_out, blk);
    check("protocol_err", protocol_err, exp_perr);
  endtask

  task automatic hold(input int seen, input logic [W-1:0] blk);
    int n = seen;
    bit stable = 1;
    for (int c = 0; c < 100 && data_out_valid; c++) begin
      tick;
      if (data_out_valid) n++;
      if (data_out !== blk) stable = 0;
    end
    check("hold_len", n, HOLD);
    check("hold_stable", stable, 1'b1);
  endtask

  typedef struct {
    int req_dly;     // ticks into the refill before need_next rises
    int req_len;     // 0: request only once FULL is reached
    bit exp_reseed;  // refill must reseed before generating
  } vec_t;

  initial begin : main
    vec_t         vecs[6];
    logic [W-1:0] blk, last_blk;
    int           bad, lat;
    bit           got;

    vecs[0] = '{0, 0, 1'b0};
    vecs[1] = '{0, 0, 1'b0};
    vecs[2] = '{0, 1, 1'b1};
    vecs[3] = '{3, 1, 1'b0};
    vecs[4] = '{0, 3, 1'b1};
    vecs[5] = '{6, 1, 1'b0};

    repeat (3) tick;
    check("rst_busy", generator_busy, 1'b1);
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_data", data_out, '0);
    check("rst_gen", core_generate, 1'b0);
    check("rst_reseed", core_reseed, 1'b0);
    check("rst_perr", protocol_err, 1'b0);
    reset = 1'b0;

    last_blk = '0;
    foreach (vecs[i]) begin
      refill(vecs[i].exp_reseed, vecs[i].req_dly, vecs[i].req_len, last_blk);
      present(vecs[i].req_len > 0, 1'b0, blk);
      hold(1, blk);
      last_blk = blk;
    end

    // core_busy raised during the hold: nothing may start until it drops.
    refill(1'b1, 0, 0, last_blk);
    present(1'b0, 1'b0, blk);
    core_busy = 1'b1;
    hold(1, blk);
    last_blk = blk;
    bad = 0;
    repeat (10) begin
      tick;
      if (core_generate || core_reseed) bad++;
    end
    check("busy_gates_start", bad, 0);
    core_busy = 1'b0;
    lat = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick;
      lat++;
      if (core_generate) got = 1;
    end
    check("gen_after_busy_lat", lat, 1);
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      tick;
      if (core_data_valid) got = 1;
    end
    check("busy_capture", got, 1'b1);

    // Stray core_data_valid while presenting.
    present(1'b0, 1'b0, blk);
    repeat (3) tick;
    man_data = {8{32'hDEAD_BEEF}};
    man_dv   = 1'b1;
    tick;
    man_dv   = 1'b0;
    check("stray_perr", protocol_err, 1'b1);
    check("stray_data", data_out, blk);
    check("stray_valid", data_out_valid, 1'b1);
    hold(5, blk);
    last_blk = blk;

    // Sticky error survives a normal cycle, then reset lands mid-presentation.
    refill(1'b1, 0, 0, last_blk);
    present(1'b0, 1'b1, blk);
    repeat (5) tick;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", data_out_valid, 1'b0);
    check("mid_rst_busy", generator_busy, 1'b1);
    check("mid_rst_data", data_out, '0);
    check("mid_rst_gen", core_generate, 1'b0);
    check("mid_rst_reseed", core_reseed, 1'b0);
    check("mid_rst_perr", protocol_err, 1'b0);
    tick;
    reset  = 1'b0;
    rd_idx = exp_q.size();
    refill(1'b0, 0, 0, '0);
    present(1'b0, 1'b0, blk);
    hold(1, blk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
